// File: rtl/sr_latch_monitor.sv
// rtl/sr_latch_monitor.sv - clocked observer of asynchronous SR latch outputs
module sr_latch_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int INVALID_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q,
  input  logic             qbar,
  input  logic             clr,
  output logic             q_sync,
  output logic [1:0]       state,
  output logic             set_pulse,
  output logic             reset_pulse,
  output logic [CNT_W-1:0] set_count,
  output logic [CNT_W-1:0] reset_count,
  output logic             invalid,
  output logic             invalid_sticky,
  output logic             evt_valid,
  output logic             evt_type,
  input  logic             evt_ready,
  output logic             evt_overflow
);

  localparam int AMB_W = $clog2(INVALID_CYCLES + 1);
  localparam logic [AMB_W-1:0] AMB_MAX = AMB_W'(INVALID_CYCLES);

  typedef enum logic [1:0] {
    ST_UNK     = 2'b00,
    ST_RESET   = 2'b01,
    ST_SET     = 2'b10,
    ST_INVALID = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] q_sync_q, q_sync_d, qb_sync_q, qb_sync_d;
  state_t                 state_q, state_d;
  logic [AMB_W-1:0]       amb_cnt_q, amb_cnt_d;
  logic                   set_pulse_q, set_pulse_d;
  logic                   reset_pulse_q, reset_pulse_d;
  logic [CNT_W-1:0]       set_count_q, set_count_d;
  logic [CNT_W-1:0]       reset_count_q, reset_count_d;
  logic                   invalid_q, invalid_d;
  logic                   invalid_sticky_q, invalid_sticky_d;
  logic                   evt_valid_q, evt_valid_d;
  logic                   evt_type_q, evt_type_d;
  logic                   evt_overflow_q, evt_overflow_d;

  logic qs, qbs;
  logic set_evt, reset_evt, accept;

  assign qs  = q_sync_q[SYNC_STAGES-1];
  assign qbs = qb_sync_q[SYNC_STAGES-1];

  // Shift both latch outputs into the clock domain.
  always_comb begin
    q_sync_d  = {q_sync_q[SYNC_STAGES-2:0], q};
    qb_sync_d = {qb_sync_q[SYNC_STAGES-2:0], qbar};
  end

  // Track latch state; ambiguous pairs only take effect once they persist.
  always_comb begin
    state_d   = state_q;
    amb_cnt_d = amb_cnt_q;
    case ({qs, qbs})
      2'b10: begin
        state_d   = ST_SET;
        amb_cnt_d = '0;
      end
      2'b01: begin
        state_d   = ST_RESET;
        amb_cnt_d = '0;
      end
      default: begin
        if (amb_cnt_q != AMB_MAX) amb_cnt_d = amb_cnt_q + AMB_W'(1);
        if (amb_cnt_d == AMB_MAX) state_d = ST_INVALID;
      end
    endcase
    // Leaving UNK is silent: only moves from a known or invalid state count.
    set_evt   = (state_d == ST_SET) &&
                (state_q == ST_RESET || state_q == ST_INVALID);
    reset_evt = (state_d == ST_RESET) &&
                (state_q == ST_SET || state_q == ST_INVALID);
  end

  // Pulses, saturating counters and sticky invalid flag; clr overrides events.
  always_comb begin
    set_pulse_d      = set_evt;
    reset_pulse_d    = reset_evt;
    invalid_d        = (state_d == ST_INVALID);
    set_count_d      = set_count_q;
    reset_count_d    = reset_count_q;
    invalid_sticky_d = invalid_sticky_q;
    if (clr) begin
      set_count_d      = '0;
      reset_count_d    = '0;
      invalid_sticky_d = 1'b0;
    end else begin
      if (set_evt && set_count_q != '1) set_count_d = set_count_q + CNT_W'(1);
      if (reset_evt && reset_count_q != '1) reset_count_d = reset_count_q + CNT_W'(1);
      if (state_d == ST_INVALID && state_q != ST_INVALID) invalid_sticky_d = 1'b1;
    end
  end

  // One-entry event register: load when free or being drained, else drop.
  always_comb begin
    accept         = evt_valid_q && evt_ready;
    evt_valid_d    = evt_valid_q;
    evt_type_d     = evt_type_q;
    evt_overflow_d = evt_overflow_q;
    if (clr) begin
      evt_valid_d    = 1'b0;
      evt_overflow_d = 1'b0;
    end else if (set_evt || reset_evt) begin
      if (!evt_valid_q || accept) begin
        evt_valid_d = 1'b1;
        evt_type_d  = set_evt;
      end else begin
        evt_overflow_d = 1'b1;
      end
    end else if (accept) begin
      evt_valid_d = 1'b0;
    end
  end

  // State register for everything above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sync_q         <= '0;
      qb_sync_q        <= '0;
      state_q          <= ST_UNK;
      amb_cnt_q        <= '0;
      set_pulse_q      <= 1'b0;
      reset_pulse_q    <= 1'b0;
      set_count_q      <= '0;
      reset_count_q    <= '0;
      invalid_q        <= 1'b0;
      invalid_sticky_q <= 1'b0;
      evt_valid_q      <= 1'b0;
      evt_type_q       <= 1'b0;
      evt_overflow_q   <= 1'b0;
    end else begin
      q_sync_q         <= q_sync_d;
      qb_sync_q        <= qb_sync_d;
      state_q          <= state_d;
      amb_cnt_q        <= amb_cnt_d;
      set_pulse_q      <= set_pulse_d;
      reset_pulse_q    <= reset_pulse_d;
      set_count_q      <= set_count_d;
      reset_count_q    <= reset_count_d;
      invalid_q        <= invalid_d;
      invalid_sticky_q <= invalid_sticky_d;
      evt_valid_q      <= evt_valid_d;
      evt_type_q       <= evt_type_d;
      evt_overflow_q   <= evt_overflow_d;
    end
  end

  assign q_sync         = qs;
  assign state          = state_q;
  assign set_pulse      = set_pulse_q;
  assign reset_pulse    = reset_pulse_q;
  assign set_count      = set_count_q;
  assign reset_count    = reset_count_q;
  assign invalid        = invalid_q;
  assign invalid_sticky = invalid_sticky_q;
  assign evt_valid      = evt_valid_q;
  assign evt_type       = evt_type_q;
  assign evt_overflow   = evt_overflow_q;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// tb/tb_sr_latch_monitor.sv - randomized and directed bench for sr_latch_monitor
module tb_sr_latch_monitor;

  localparam int SYNC = 2;
  localparam int INV  = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          q = 1'b0, qbar = 1'b0, clr = 1'b0, evt_ready = 1'b0;
  logic          q_sync, set_pulse, reset_pulse, invalid, invalid_sticky;
  logic          evt_valid, evt_type, evt_overflow;
  logic [1:0]    state;
  logic [CW-1:0] set_count, reset_count;

  int n_cmp  = 0;
  int n_fail = 0;

  sr_latch_monitor #(.SYNC_STAGES(SYNC), .INVALID_CYCLES(INV), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .q(q), .qbar(qbar), .clr(clr),
    .q_sync(q_sync), .state(state), .set_pulse(set_pulse), .reset_pulse(reset_pulse),
    .set_count(set_count), .reset_count(reset_count), .invalid(invalid),
    .invalid_sticky(invalid_sticky), .evt_valid(evt_valid), .evt_type(evt_type),
    .evt_ready(evt_ready), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: history of sampled input pairs plus the observable results.
  bit [1:0] m_hist[$];
  int       m_amb;
  bit [1:0] m_state;
  bit       m_qs, m_setp, m_resp, m_inv, m_sticky, m_valid, m_type, m_ovf;
  int       m_setc, m_resc;

  function automatic void model_reset();
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_front(2'b00);
    m_amb = 0; m_state = 2'b00; m_qs = 0; m_setp = 0; m_resp = 0; m_inv = 0;
    m_sticky = 0; m_valid = 0; m_type = 0; m_ovf = 0; m_setc = 0; m_resc = 0;
  endfunction

  function automatic void model_step();
    bit [1:0] seen = m_hist[SYNC-1];
    bit [1:0] nxt  = m_state;
    bit       acc  = m_valid && evt_ready;
    bit       se, re;
    if (seen == 2'b10) begin nxt = 2'b10; m_amb = 0; end
    else if (seen == 2'b01) begin nxt = 2'b01; m_amb = 0; end
    else begin m_amb++; if (m_amb >= INV) nxt = 2'b11; end
    se = (nxt == 2'b10) && (m_state == 2'b01 || m_state == 2'b11);
    re = (nxt == 2'b01) && (m_state == 2'b10 || m_state == 2'b11);
    m_setp = se; m_resp = re;
    if (clr) begin
      m_setc = 0; m_resc = 0; m_sticky = 0; m_valid = 0; m_ovf = 0;
    end else begin
      if (se) m_setc = (m_setc + 1 > CMAX) ? CMAX : m_setc + 1;
      if (re) m_resc = (m_resc + 1 > CMAX) ? CMAX : m_resc + 1;
      if (nxt == 2'b11 && m_state != 2'b11) m_sticky = 1;
      if (se || re) begin
        if (!m_valid || acc) begin m_valid = 1; m_type = se; end
        else m_ovf = 1;
      end else if (acc) m_valid = 0;
    end
    m_state = nxt;
    m_inv = (nxt == 2'b11);
    m_hist.push_front({q, qbar});
    void'(m_hist.pop_back());
    m_qs = m_hist[SYNC-1][1];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit [1:0] p);
    q = p[1]; qbar = p[0];
  endtask

  task automatic test_reset();
    rst_n = 0; drive(2'b01);
    tick(); tick();
    n_cmp++;
    if ({q_sync, state, set_pulse, reset_pulse, set_count, reset_count, invalid,
         invalid_sticky, evt_valid, evt_type, evt_overflow} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got state=%b cnt=%0d/%0d valid=%b want all zero",
                         state, set_count, reset_count, evt_valid);
    end
  endtask

  task automatic test_init_no_event();
    rst_n = 1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++;
      if (set_pulse !== 0 || reset_pulse !== 0 || evt_valid !== 0) begin
        n_fail++; $display("FAIL init_no_event c%0d: pulses=%b%b valid=%b want 000",
                           c, set_pulse, reset_pulse, evt_valid);
      end
    end
    n_cmp++;
    if (state !== 2'b01 || set_count !== 0 || reset_count !== 0) begin
      n_fail++; $display("FAIL init_state: state=%b counts=%0d/%0d want 01 0/0",
                         state, set_count, reset_count);
    end
  endtask

  task automatic test_set_then_reset();
    evt_ready = 0; drive(2'b10);
    tick(); tick();
    n_cmp++;
    if (set_pulse !== 0) begin n_fail++; $display("FAIL set_early: set_pulse=%b want 0", set_pulse); end
    tick();
    n_cmp++;
    if (set_pulse !== 1 || evt_valid !== 1 || evt_type !== 1 || state !== 2'b10) begin
      n_fail++; $display("FAIL set_event: pulse=%b valid=%b type=%b state=%b want 1 1 1 10",
                         set_pulse, evt_valid, evt_type, state);
    end
    repeat (7) tick();
    drive(2'b01);
    repeat (3) tick();
    n_cmp++;
    if (reset_pulse !== 1 || evt_overflow !== 1 || evt_type !== 1 || evt_valid !== 1) begin
      n_fail++; $display("FAIL reset_overflow: pulse=%b ovf=%b type=%b valid=%b want 1 1 1 1",
                         reset_pulse, evt_overflow, evt_type, evt_valid);
    end
    n_cmp++;
    if (set_count !== 1 || reset_count !== 1) begin
      n_fail++; $display("FAIL counts_1_1: got %0d/%0d want 1/1", set_count, reset_count);
    end
  endtask

  task automatic test_forbidden();
    drive(2'b11);
    repeat (5) tick();
    n_cmp++;
    if (invalid !== 0) begin n_fail++; $display("FAIL invalid_early: got %b want 0", invalid); end
    tick();
    n_cmp++;
    if (invalid !== 1 || invalid_sticky !== 1 || state !== 2'b11) begin
      n_fail++; $display("FAIL invalid_rise: inv=%b sticky=%b state=%b want 1 1 11",
                         invalid, invalid_sticky, state);
    end
    repeat (4) tick();
    drive(2'b10);
    repeat (3) tick();
    n_cmp++;
    if (set_pulse !== 1 || state !== 2'b10 || invalid !== 0 || invalid_sticky !== 1) begin
      n_fail++; $display("FAIL invalid_recover: pulse=%b state=%b inv=%b sticky=%b want 1 10 0 1",
                         set_pulse, state, invalid, invalid_sticky);
    end
  endtask

  task automatic test_glitch();
    repeat (3) tick();
    drive(2'b11);
    repeat (3) tick();
    drive(2'b10);
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (state !== 2'b10 || set_pulse !== 0 || reset_pulse !== 0 || invalid !== 0) begin
        n_fail++; $display("FAIL glitch c%0d: state=%b pulses=%b%b inv=%b want 10 00 0",
                           c, state, set_pulse, reset_pulse, invalid);
      end
    end
  endtask

  task automatic test_saturation_clr();
    for (int i = 0; i < 5; i++) begin
      drive(2'b01); repeat (6) tick();
      drive(2'b10); repeat (6) tick();
    end
    n_cmp++;
    if (set_count !== 2'd3 || reset_count !== 2'd3) begin
      n_fail++; $display("FAIL saturate: got %0d/%0d want 3/3", set_count, reset_count);
    end
    drive(2'b01); repeat (6) tick();
    drive(2'b10); tick(); tick();
    clr = 1; tick(); clr = 0;
    n_cmp++;
    if (set_pulse !== 1 || set_count !== 0 || reset_count !== 0 || evt_valid !== 0 || evt_overflow !== 0) begin
      n_fail++; $display("FAIL clr_wins: pulse=%b cnt=%0d/%0d valid=%b ovf=%b want 1 0/0 0 0",
                         set_pulse, set_count, reset_count, evt_valid, evt_overflow);
    end
  endtask

  task automatic test_back_to_back();
    drive(2'b01); repeat (4) tick();
    evt_ready = 1; tick(); evt_ready = 0;
    drive(2'b10); repeat (4) tick();
    n_cmp++;
    if (evt_valid !== 1 || evt_type !== 1) begin
      n_fail++; $display("FAIL b2b_held: valid=%b type=%b want 1 1", evt_valid, evt_type);
    end
    drive(2'b01); tick(); tick();
    evt_ready = 1; tick(); evt_ready = 0;
    n_cmp++;
    if (reset_pulse !== 1 || evt_valid !== 1 || evt_type !== 0 || evt_overflow !== 0) begin
      n_fail++; $display("FAIL b2b_accept_load: pulse=%b valid=%b type=%b ovf=%b want 1 1 0 0",
                         reset_pulse, evt_valid, evt_type, evt_overflow);
    end
  endtask

  task automatic test_async_reset();
    drive(2'b10); tick(); #2;
    rst_n = 0; model_reset(); #1;
    n_cmp++;
    if ({state, invalid_sticky, evt_valid, evt_overflow, set_count, reset_count, q_sync} !== '0) begin
      n_fail++; $display("FAIL async_reset: state=%b valid=%b ovf=%b cnt=%0d/%0d want zeros",
                         state, evt_valid, evt_overflow, set_count, reset_count);
    end
    @(negedge clk); rst_n = 1;
    repeat (3) tick();
    n_cmp++;
    if (state !== 2'b10 || set_pulse !== 0 || evt_valid !== 0) begin
      n_fail++; $display("FAIL reset_first_pair: state=%b pulse=%b valid=%b want 10 0 0",
                         state, set_pulse, evt_valid);
    end
  endtask

  task automatic test_random();
    int hold, r;
    bit [1:0] p;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        p = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b11 : 2'b00;
        drive(p);
        hold = $urandom_range(1, 7);
      end
      hold--;
      evt_ready = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 24) == 0);
      tick();
      n_cmp++;
      if ({q_sync, state, set_pulse, reset_pulse, set_count, reset_count, invalid,
           invalid_sticky, evt_valid, evt_type, evt_overflow} !==
          {m_qs, m_state, m_setp, m_resp, CW'(m_setc), CW'(m_resc), m_inv,
           m_sticky, m_valid, m_type, m_ovf}) begin
        n_fail++;
        $display("FAIL random c%0d: state=%b p=%b%b cnt=%0d/%0d inv=%b st=%b v=%b t=%b o=%b want state=%b p=%b%b cnt=%0d/%0d inv=%b st=%b v=%b t=%b o=%b",
                 c, state, set_pulse, reset_pulse, set_count, reset_count, invalid, invalid_sticky,
                 evt_valid, evt_type, evt_overflow, m_state, m_setp, m_resp, m_setc, m_resc, m_inv,
                 m_sticky, m_valid, m_type, m_ovf);
      end
    end
    clr = 0; evt_ready = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_no_event();
    test_set_then_reset();
    test_forbidden();
    test_glitch();
    test_saturation_clr();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
